// File: rtl/pwm_capture_if.sv
// Wishbone classic slave bus bundle for pwm_capture.
// The master modport is the bus side; the slave modport is the capture block.
interface pwm_capture_if;
    logic [1:0]  WBs_ADR_i;
    logic        WBs_CYC_i;
    logic        WBs_STB_i;
    logic        WBs_WE_i;
    logic [31:0] WBs_DAT_i;
    logic [31:0] WBs_DAT_o;
    logic        WBs_ACK_o;

    modport master (
        output WBs_ADR_i,
        output WBs_CYC_i,
        output WBs_STB_i,
        output WBs_WE_i,
        output WBs_DAT_i,
        input  WBs_DAT_o,
        input  WBs_ACK_o
    );

    modport slave (
        input  WBs_ADR_i,
        input  WBs_CYC_i,
        input  WBs_STB_i,
        input  WBs_WE_i,
        input  WBs_DAT_i,
        output WBs_DAT_o,
        output WBs_ACK_o
    );
endinterface

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of pwm_i in clk_i cycles and
// exposes CTRL/STATUS/HIGH/PERIOD over a single-cycle-ACK Wishbone slave.
module pwm_capture #(
    parameter int unsigned CNT_W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    pwm_capture_if.slave wb,
    input  logic         pwm_i,
    output logic         irq_o
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitRise,
        StMeasure
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic             sync1_q, sync2_q, prev_q;
    logic             rise, fall;
    state_e           state_q, state_d;
    logic             publish, ovf_hit, cnt_full;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_tmp_q, hi_tmp_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             en_q, en_d;
    logic             irq_en_q, irq_en_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic             irq_q, irq_d;
    logic             req, wr, wr_ctrl, wr_status;
    logic [31:0]      rdata;
    logic             unused_dat;

    // Only the two low data bits carry register state.
    assign unused_dat = ^wb.WBs_DAT_i[31:2];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pwm_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise     = sync2_q & ~prev_q;
    assign fall     = ~sync2_q & prev_q;
    assign cnt_full = (cnt_q == CntMax);

    assign req       = wb.WBs_CYC_i & wb.WBs_STB_i & ~ack_q;
    assign wr        = req & wb.WBs_WE_i;
    assign wr_ctrl   = wr & (wb.WBs_ADR_i == 2'd0);
    assign wr_status = wr & (wb.WBs_ADR_i == 2'd1);

    always_comb begin
        state_d = state_q;
        publish = 1'b0;
        ovf_hit = 1'b0;
        if (!en_q) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:     state_d = StWaitRise;
                StWaitRise: if (rise) state_d = StMeasure;
                StMeasure: begin
                    if (rise) begin
                        publish = 1'b1;
                    end else if (cnt_full) begin
                        // No rise within the counter range: 0%/100% duty or a dead input.
                        ovf_hit = 1'b1;
                        state_d = StWaitRise;
                    end
                end
                default:    state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        hi_tmp_d = hi_tmp_q;
        if (!en_q || state_q == StIdle) begin
            cnt_d    = '0;
            hi_tmp_d = '0;
        end else begin
            if (rise) begin
                cnt_d = CntOne;
            end else if (state_q == StMeasure && !cnt_full) begin
                cnt_d = cnt_q + CntOne;
            end
            if (state_q == StMeasure && fall) begin
                hi_tmp_d = cnt_q;
            end
        end
    end

    always_comb begin
        high_d   = high_q;
        period_d = period_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        if (publish) begin
            high_d   = hi_tmp_q;
            period_d = cnt_q;
        end
        if (wr_ctrl) begin
            en_d     = wb.WBs_DAT_i[0];
            irq_en_d = wb.WBs_DAT_i[1];
        end
        if (wr_status && wb.WBs_DAT_i[0]) valid_d = 1'b0;
        if (wr_status && wb.WBs_DAT_i[1]) ovf_d = 1'b0;
        // Hardware set takes priority over a coincident software clear.
        if (publish) valid_d = 1'b1;
        if (ovf_hit) ovf_d = 1'b1;
    end

    always_comb begin
        rdata = '0;
        unique case (wb.WBs_ADR_i)
            2'd0: rdata = {30'b0, irq_en_q, en_q};
            2'd1: rdata = {30'b0, ovf_q, valid_q};
            2'd2: rdata = 32'(high_q);
            2'd3: rdata = 32'(period_q);
            default: rdata = '0;
        endcase
    end

    // Read data is sampled from pre-update registers, so a coincident publish is not seen.
    assign ack_d = req;
    assign dat_d = req ? rdata : 32'd0;
    assign irq_d = irq_en_q & valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hi_tmp_q <= '0;
            high_q   <= '0;
            period_q <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_tmp_q <= hi_tmp_d;
            high_q   <= high_d;
            period_q <= period_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            irq_q    <= irq_d;
        end
    end

    assign wb.WBs_ACK_o = ack_q;
    assign wb.WBs_DAT_o = dat_q;
    assign irq_o        = irq_q;

endmodule
